rv32i_instr_encoder: RTL and testbench
======================================

Name: rv32i_instr_encoder

Overview:
- Inverse of the control decoder: converts a symbolic RV32I request (mnemonic code, rd, rs1, rs2, immediate) into a 32-bit instruction word.
- Encoded words go into a 2-entry FIFO and are emitted with a sequential instruction-memory address, so a bench or loader can fill instruction RAM for the single-cycle CPU.
- Requests that cannot be encoded are rejected and counted, and never enter the FIFO.

Parameters:
AW, 8, width of out_addr and addr_value (word address)
ECW, 8, width of err_count (saturating)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  request valid
in_ready  out  1  encoder can accept request
in_mnem  in  6  mnemonic code (table below)
in_rd  in  5  destination register
in_rs1  in  5  source register 1
in_rs2  in  5  source register 2
in_imm  in  32  immediate, two's complement byte offset/value
addr_load  in  1  load address counter
addr_value  in  AW  value for address counter
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head
out_word  out  32  encoded instruction at head
out_addr  out  AW  word address for head
err_illegal  out  1  one-cycle pulse: request rejected
err_count  out  ECW  rejected-request count, saturates at all-ones

Behaviour:
- Mnemonic codes:
  - 0 lui, 1 auipc, 2 jal, 3 jalr
  - 4–9 beq, bne, blt, bge, bltu, bgeu
  - 10–14 lb, lh, lw, lbu, lhu
  - 15–17 sb, sh, sw
  - 18–23 addi, slti, sltiu, xori, ori, andi
  - 24–26 slli, srli, srai
  - 27–36 add, sub, sll, slt, sltu, xor, srl, sra, or, and
  - 37–63 illegal.
- Encoding is standard RV32I. Opcode, funct3 and funct7 (bit 30 set for sub, sra, srai) match the decoder's op/func3/func7 decode.
- Fields not used by a format are zero (e.g. rs2 for I-type, rd for S/B).
- Immediate legality is checked combinationally on in_imm:
  - I/S (jalr, loads, stores, ALU-imm): signed 12-bit, -2048..2047.
  - Shifts: in_imm[31:5]==0; shamt=in_imm[4:0].
  - B: signed 13-bit, even.
  - J: signed 21-bit, even.
  - U: in_imm[11:0]==0; word[31:12]=in_imm[31:12].
  - R-type: in_imm ignored, always legal.
- Accept occurs when in_valid && in_ready.
  - Legal request: encoded word is pushed into the FIFO.
  - Illegal request (bad mnemonic or immediate): err_illegal=1 on the next cycle, err_count+1 (saturating), no push.
- in_ready = FIFO not full. It is combinational from FIFO state only and does not depend on in_valid.
- FIFO: 2 entries.
  - out_valid = not empty; out_word is the head entry, registered.
  - Latency from accept to out_valid is 1 cycle when the FIFO is empty.
  - Pop occurs on out_valid && out_ready.
  - Simultaneous push and pop while full: not possible, because in_ready=0.
  - Simultaneous push and pop with 1 entry: count stays 1, head advances.
- Address counter (AW bits):
  - out_addr = counter.
  - The counter increments by 1 on each pop and wraps from all-ones to 0.
  - addr_load has priority over increment in the same cycle. The loaded value is visible next cycle.
  - Loading does not affect FIFO contents.
- Reset (async, rst_n=0), all registers clear:
  - FIFO empty, out_valid=0, out_word=0
  - counter=0, out_addr=0
  - err_illegal=0, err_count=0
  - in_ready=0 while rst_n=0; in_ready=1 from the first clock after release.
- Reset mid-operation discards buffered words with no output handshake.
- No output may change while out_valid=1 and out_ready=0; the head is held stable.

Test Plan:
- Reset release; out_ready=1; one request each: addi x1,x0,5 → 0x00500093 at addr 0; lui x2,0x12345000 → 0x12345137 at addr 1; sub x3,x1,x2 → 0x402081B3 at addr 2; each appears 1 cycle after accept.
- beq x1,x2,+8 → 0x00208463; srai x5,x6,3 → 0x40335293; jal x1,-4 → 0xFFDFF0EF.
- addi imm=2048, beq imm=3, lui imm=0x1001, mnem=40 → each gives an err_illegal pulse with no out_valid; err_count=4; then a legal request still encodes correctly.
- out_ready=0, three back-to-back valid requests → in_ready drops after 2 accepts; head holds the first word. Raise out_ready → words pop in order at addrs 0,1; third accepted only after space frees.
- addr_load=1, addr_value=0xFE, then 3 pops → out_addr 0xFE, 0xFF, 0x00 (wrap). addr_load on the same cycle as a pop → loaded value wins.
- Assert rst_n=0 with 2 entries buffered and err_count=5 → out_valid=0, err_count=0, out_addr=0 immediately (async, no clock edge needed).

Source files
------------

// File: rtl/rv32i_instr_encoder.sv
// ---------------------------------------------------------------------------
// rv32i_instr_encoder
//
// Turns a symbolic RV32I request (mnemonic code, rd, rs1, rs2, immediate) into
// a 32-bit instruction word. Legal words go into a 2-entry FIFO and leave it
// tagged with a sequential instruction-memory word address, so a loader can
// stream them straight into instruction RAM. Requests with an unknown
// mnemonic or an immediate that does not fit the format are dropped. Each
// drop raises a one-cycle error pulse and bumps a saturating counter.
//
// Ports
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   in_valid       request valid
//   in_ready       encoder can accept (FIFO not full, out of reset)
//   in_mnem        mnemonic code 0..36, 37..63 illegal
//   in_rd/rs1/rs2  register fields
//   in_imm         immediate, two's complement byte offset / value
//   addr_load      load the address counter with addr_value
//   addr_value     value for the address counter
//   out_valid      FIFO head valid
//   out_ready      consumer accepts the head
//   out_word       encoded instruction at the head
//   out_addr       word address of the head
//   err_illegal    one-cycle pulse after a rejected request
//   err_count      rejected-request count, saturates at all-ones
// ---------------------------------------------------------------------------
module rv32i_instr_encoder #(
    parameter int AW  = 8,
    parameter int ECW = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [5:0]     in_mnem,
    input  logic [4:0]     in_rd,
    input  logic [4:0]     in_rs1,
    input  logic [4:0]     in_rs2,
    input  logic [31:0]    in_imm,
    input  logic           addr_load,
    input  logic [AW-1:0]  addr_value,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [31:0]    out_word,
    output logic [AW-1:0]  out_addr,
    output logic           err_illegal,
    output logic [ECW-1:0] err_count
);

    typedef enum logic [2:0] {
        FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD
    } fmt_e;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_ALU    = 7'b0110011;

    fmt_e        fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_b30;   // the only funct7 bit RV32I base ever sets
    logic        imm_ok;
    logic        enc_legal;
    logic [31:0] enc_word;

    // ------------------------------------------------------------------
    // Mnemonic decode: format, opcode, funct3, funct7[5]
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise any path that skips an assignment infers a latch.
        fmt        = FMT_BAD;
        opcode     = 7'b0;
        funct3     = 3'b000;
        funct7_b30 = 1'b0;
        case (in_mnem)
            6'd0:  begin fmt = FMT_U;  opcode = OP_LUI;                        end
            6'd1:  begin fmt = FMT_U;  opcode = OP_AUIPC;                      end
            6'd2:  begin fmt = FMT_J;  opcode = OP_JAL;                        end
            6'd3:  begin fmt = FMT_I;  opcode = OP_JALR;   funct3 = 3'b000;    end
            6'd4:  begin fmt = FMT_B;  opcode = OP_BRANCH; funct3 = 3'b000;    end
            6'd5:  begin fmt = FMT_B;  opcode = OP_BRANCH; funct3 = 3'b001;    end
            6'd6:  begin fmt = FMT_B;  opcode = OP_BRANCH; funct3 = 3'b100;    end
            6'd7:  begin fmt = FMT_B;  opcode = OP_BRANCH; funct3 = 3'b101;    end
            6'd8:  begin fmt = FMT_B;  opcode = OP_BRANCH; funct3 = 3'b110;    end
            6'd9:  begin fmt = FMT_B;  opcode = OP_BRANCH; funct3 = 3'b111;    end
            6'd10: begin fmt = FMT_I;  opcode = OP_LOAD;   funct3 = 3'b000;    end
            6'd11: begin fmt = FMT_I;  opcode = OP_LOAD;   funct3 = 3'b001;    end
            6'd12: begin fmt = FMT_I;  opcode = OP_LOAD;   funct3 = 3'b010;    end
            6'd13: begin fmt = FMT_I;  opcode = OP_LOAD;   funct3 = 3'b100;    end
            6'd14: begin fmt = FMT_I;  opcode = OP_LOAD;   funct3 = 3'b101;    end
            6'd15: begin fmt = FMT_S;  opcode = OP_STORE;  funct3 = 3'b000;    end
            6'd16: begin fmt = FMT_S;  opcode = OP_STORE;  funct3 = 3'b001;    end
            6'd17: begin fmt = FMT_S;  opcode = OP_STORE;  funct3 = 3'b010;    end
            6'd18: begin fmt = FMT_I;  opcode = OP_ALUI;   funct3 = 3'b000;    end
            6'd19: begin fmt = FMT_I;  opcode = OP_ALUI;   funct3 = 3'b010;    end
            6'd20: begin fmt = FMT_I;  opcode = OP_ALUI;   funct3 = 3'b011;    end
            6'd21: begin fmt = FMT_I;  opcode = OP_ALUI;   funct3 = 3'b100;    end
            6'd22: begin fmt = FMT_I;  opcode = OP_ALUI;   funct3 = 3'b110;    end
            6'd23: begin fmt = FMT_I;  opcode = OP_ALUI;   funct3 = 3'b111;    end
            6'd24: begin fmt = FMT_SH; opcode = OP_ALUI;   funct3 = 3'b001;    end
            6'd25: begin fmt = FMT_SH; opcode = OP_ALUI;   funct3 = 3'b101;    end
            6'd26: begin fmt = FMT_SH; opcode = OP_ALUI;   funct3 = 3'b101;
                         funct7_b30 = 1'b1;                                    end
            6'd27: begin fmt = FMT_R;  opcode = OP_ALU;    funct3 = 3'b000;    end
            6'd28: begin fmt = FMT_R;  opcode = OP_ALU;    funct3 = 3'b000;
                         funct7_b30 = 1'b1;                                    end
            6'd29: begin fmt = FMT_R;  opcode = OP_ALU;    funct3 = 3'b001;    end
            6'd30: begin fmt = FMT_R;  opcode = OP_ALU;    funct3 = 3'b010;    end
            6'd31: begin fmt = FMT_R;  opcode = OP_ALU;    funct3 = 3'b011;    end
            6'd32: begin fmt = FMT_R;  opcode = OP_ALU;    funct3 = 3'b100;    end
            6'd33: begin fmt = FMT_R;  opcode = OP_ALU;    funct3 = 3'b101;    end
            6'd34: begin fmt = FMT_R;  opcode = OP_ALU;    funct3 = 3'b101;
                         funct7_b30 = 1'b1;                                    end
            6'd35: begin fmt = FMT_R;  opcode = OP_ALU;    funct3 = 3'b110;    end
            6'd36: begin fmt = FMT_R;  opcode = OP_ALU;    funct3 = 3'b111;    end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Immediate range check. A value fits in N signed bits when all bits
    // from N-1 upward are copies of the sign bit.
    // ------------------------------------------------------------------
    always_comb begin
        imm_ok = 1'b0;
        case (fmt)
            FMT_R:        imm_ok = 1'b1;
            FMT_I, FMT_S: imm_ok = (&in_imm[31:11]) || (~|in_imm[31:11]);
            FMT_SH:       imm_ok = ~|in_imm[31:5];
            FMT_B:        imm_ok = ((&in_imm[31:12]) || (~|in_imm[31:12])) && !in_imm[0];
            FMT_J:        imm_ok = ((&in_imm[31:20]) || (~|in_imm[31:20])) && !in_imm[0];
            FMT_U:        imm_ok = ~|in_imm[11:0];
            default:      imm_ok = 1'b0;
        endcase
    end

    assign enc_legal = (fmt != FMT_BAD) && imm_ok;

    // ------------------------------------------------------------------
    // Field packing. Fields a format does not use are left as zero.
    // ------------------------------------------------------------------
    always_comb begin
        enc_word = 32'b0;
        case (fmt)
            FMT_R:  enc_word = {1'b0, funct7_b30, 5'b0, in_rs2, in_rs1, funct3, in_rd, opcode};
            FMT_SH: enc_word = {1'b0, funct7_b30, 5'b0, in_imm[4:0], in_rs1, funct3, in_rd, opcode};
            FMT_I:  enc_word = {in_imm[11:0], in_rs1, funct3, in_rd, opcode};
            FMT_S:  enc_word = {in_imm[11:5], in_rs2, in_rs1, funct3, in_imm[4:0], opcode};
            FMT_B:  enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, funct3,
                                in_imm[4:1], in_imm[11], opcode};
            FMT_U:  enc_word = {in_imm[31:12], in_rd, opcode};
            FMT_J:  enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                                in_rd, opcode};
            default: enc_word = 32'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // 2-entry FIFO (head/tail registers), address counter, error tracking
    // ------------------------------------------------------------------
    logic [31:0]    head_q;
    logic [31:0]    tail_q;
    logic [1:0]     count_q;
    logic           ready_q;     // low in reset, high from the first clock after
    logic [AW-1:0]  addr_q;
    logic           err_q;
    logic [ECW-1:0] err_cnt_q;

    logic accept;
    logic push;
    logic pop;

    assign out_valid = (count_q != 2'd0);
    assign in_ready  = ready_q && (count_q != 2'd2);
    assign accept    = in_valid && in_ready;
    assign push      = accept && enc_legal;
    assign pop       = out_valid && out_ready;

    assign out_word    = head_q;
    assign out_addr    = addr_q;
    assign err_illegal = err_q;
    assign err_count   = err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the FIFO storage is reset too, because out_word must read
            // zero after reset; a plain RAM would normally be left unreset.
            head_q    <= 32'b0;
            tail_q    <= 32'b0;
            count_q   <= 2'd0;
            ready_q   <= 1'b0;
            addr_q    <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of order.
            ready_q <= 1'b1;

            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) head_q <= enc_word;
                    else                 tail_q <= enc_word;
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    head_q  <= tail_q;
                    count_q <= count_q - 2'd1;
                end
                // Push with pop is only reachable at one entry: the new
                // word becomes the head and the count is unchanged.
                2'b11: head_q <= enc_word;
                default: ;
            endcase

            if (addr_load)  addr_q <= addr_value;
            else if (pop)   addr_q <= addr_q + AW'(1);

            err_q <= accept && !enc_legal;
            if (accept && !enc_legal && (err_cnt_q != '1))
                err_cnt_q <= err_cnt_q + ECW'(1);
        end
    end

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_rv32i_instr_encoder
//
// Self-checking bench for rv32i_instr_encoder. A behavioural model (queue of
// expected words, integer address counter, error counter, and an encoder
// written from the RV32I field layouts using plain arithmetic) tracks the
// design. A compare process checks every DUT output against the model on
// each falling edge. Directed sequences pin the model with hand-computed
// words, and a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_rv32i_instr_encoder;

    localparam int AW  = 8;
    localparam int ECW = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [5:0]     in_mnem;
    logic [4:0]     in_rd;
    logic [4:0]     in_rs1;
    logic [4:0]     in_rs2;
    logic [31:0]    in_imm;
    logic           addr_load;
    logic [AW-1:0]  addr_value;
    logic           out_valid;
    logic           out_ready;
    logic [31:0]    out_word;
    logic [AW-1:0]  out_addr;
    logic           err_illegal;
    logic [ECW-1:0] err_count;

    rv32i_instr_encoder #(.AW(AW), .ECW(ECW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_mnem     (in_mnem),
        .in_rd       (in_rd),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_imm      (in_imm),
        .addr_load   (addr_load),
        .addr_value  (addr_value),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_word    (out_word),
        .out_addr    (out_addr),
        .err_illegal (err_illegal),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference encoder
    // ------------------------------------------------------------------
    typedef enum int {K_R, K_I, K_SH, K_S, K_B, K_U, K_J, K_BAD} kind_e;

    localparam int BR_F3 [6]  = '{0, 1, 4, 5, 6, 7};
    localparam int LD_F3 [5]  = '{0, 1, 2, 4, 5};
    localparam int AI_F3 [6]  = '{0, 2, 3, 4, 6, 7};
    localparam int SH_F3 [3]  = '{1, 5, 5};
    localparam int R_F3  [10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};

    function automatic bit model_enc(input int m, input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic [31:0] imm,
                                     output logic [31:0] w);
        kind_e       k;
        logic [31:0] op, f3, f7, d, s1, s2;
        int          v;
        bit          ok;
        k = K_BAD; op = 0; f3 = 0; f7 = 0; ok = 0; w = 0;
        d = 32'(rd); s1 = 32'(rs1); s2 = 32'(rs2);
        v = $signed(imm);
        if (m == 0)                 begin k = K_U; op = 32'h37; end
        else if (m == 1)            begin k = K_U; op = 32'h17; end
        else if (m == 2)            begin k = K_J; op = 32'h6F; end
        else if (m == 3)            begin k = K_I; op = 32'h67; end
        else if (m >= 4 && m <= 9)  begin k = K_B; op = 32'h63; f3 = BR_F3[m-4]; end
        else if (m >= 10 && m <= 14) begin k = K_I; op = 32'h03; f3 = LD_F3[m-10]; end
        else if (m >= 15 && m <= 17) begin k = K_S; op = 32'h23; f3 = 32'(m - 15); end
        else if (m >= 18 && m <= 23) begin k = K_I; op = 32'h13; f3 = AI_F3[m-18]; end
        else if (m >= 24 && m <= 26) begin
            k = K_SH; op = 32'h13; f3 = SH_F3[m-24]; f7 = (m == 26) ? 32'h20 : 32'h0;
        end
        else if (m >= 27 && m <= 36) begin
            k = K_R; op = 32'h33; f3 = R_F3[m-27];
            f7 = (m == 28 || m == 34) ? 32'h20 : 32'h0;
        end
        case (k)
            K_R: begin
                ok = 1;
                w = (f7 << 25) | (s2 << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | op;
            end
            K_SH: begin
                ok = (imm < 32);
                w = (f7 << 25) | ((imm & 32'h1F) << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | op;
            end
            K_I: begin
                ok = (v >= -2048) && (v <= 2047);
                w = ((imm & 32'hFFF) << 20) | (s1 << 15) | (f3 << 12) | (d << 7) | op;
            end
            K_S: begin
                ok = (v >= -2048) && (v <= 2047);
                w = (((imm >> 5) & 32'h7F) << 25) | (s2 << 20) | (s1 << 15) | (f3 << 12)
                    | ((imm & 32'h1F) << 7) | op;
            end
            K_B: begin
                ok = (v >= -4096) && (v <= 4095) && ((imm & 1) == 0);
                w = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (s2 << 20)
                    | (s1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8)
                    | (((imm >> 11) & 1) << 7) | op;
            end
            K_U: begin
                ok = ((imm & 32'hFFF) == 0);
                w = (imm & 32'hFFFFF000) | (d << 7) | op;
            end
            K_J: begin
                ok = (v >= -1048576) && (v <= 1048575) && ((imm & 1) == 0);
                w = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                    | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                    | (d << 7) | op;
            end
            default: ok = 0;
        endcase
        return ok;
    endfunction

    // ------------------------------------------------------------------
    // Behavioural model state
    // ------------------------------------------------------------------
    logic [31:0]   m_q[$];
    logic [AW-1:0] m_addr;
    bit            m_err;
    int            m_err_cnt;
    bit            m_rdy;
    bit            cmp_en = 0;

    always @(posedge clk or negedge rst_n) begin
        bit          can_take;
        bit          do_pop;
        bit          ok;
        logic [31:0] w;
        if (!rst_n) begin
            m_q.delete();
            m_addr    = '0;
            m_err     = 0;
            m_err_cnt = 0;
            m_rdy     = 0;
        end else begin
            can_take = m_rdy && (m_q.size() < 2);
            do_pop   = (m_q.size() > 0) && out_ready;
            ok       = model_enc(int'(in_mnem), in_rd, in_rs1, in_rs2, in_imm, w);
            if (addr_load)   m_addr = addr_value;
            else if (do_pop) m_addr = m_addr + 1'b1;
            if (do_pop) void'(m_q.pop_front());
            if (in_valid && can_take) begin
                if (ok) m_q.push_back(w);
                m_err = !ok;
                if (!ok && m_err_cnt < 255) m_err_cnt++;
            end else begin
                m_err = 0;
            end
            m_rdy = 1;
        end
    end

    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            check("in_ready",    in_ready,    m_rdy && (m_q.size() < 2));
            check("out_valid",   out_valid,   m_q.size() > 0);
            if (m_q.size() > 0) check("out_word", out_word, m_q[0]);
            check("out_addr",    out_addr,    m_addr);
            check("err_illegal", err_illegal, m_err);
            check("err_count",   err_count,   m_err_cnt);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic drive_req(input int m, input int rd, input int rs1, input int rs2,
                             input logic [31:0] imm);
        in_valid = 1'b1;
        in_mnem  = 6'(m);
        in_rd    = 5'(rd);
        in_rs1   = 5'(rs1);
        in_rs2   = 5'(rs2);
        in_imm   = imm;
    endtask

    // Holds the request until an edge where in_ready was high, then drops
    // in_valid 1 time unit after that edge. Bounded to 20 cycles.
    task automatic wait_accept(input string name);
        bit got;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (in_ready) got = 1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check({name, "_accepted"}, got, 1);
    endtask

    task automatic send_expect(input string name, input int m, input int rd, input int rs1,
                               input int rs2, input logic [31:0] imm,
                               input logic [31:0] exp_word, input logic [AW-1:0] exp_addr);
        drive_req(m, rd, rs1, rs2, imm);
        wait_accept(name);
        @(negedge clk);
        check({name, "_valid"}, out_valid, 1);
        check({name, "_word"},  out_word,  exp_word);
        check({name, "_addr"},  out_addr,  exp_addr);
    endtask

    task automatic send_bad(input string name, input int m, input logic [31:0] imm);
        drive_req(m, 1, 2, 3, imm);
        wait_accept(name);
        @(negedge clk);
        check({name, "_err"},   err_illegal, 1);
        check({name, "_valid"}, out_valid,   0);
    endtask

    localparam logic [31:0] BND [13] = '{
        32'd2047, 32'd2048, 32'hFFFFF800, 32'hFFFFF7FF, 32'd4094, 32'd4095,
        32'hFFFFF000, 32'hFFFFEFFE, 32'h000FFFFE, 32'h00100000, 32'hFFF00000,
        32'd31, 32'd32
    };

    logic [31:0] pw;
    logic [31:0] wa, wb, wc;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_mnem = '0; in_rd = '0; in_rs1 = '0;
        in_rs2 = '0; in_imm = '0; addr_load = 1'b0; addr_value = '0; out_ready = 1'b0;

        // Reset values
        #12;
        check("rst_in_ready",    in_ready,    0);
        check("rst_out_valid",   out_valid,   0);
        check("rst_out_word",    out_word,    0);
        check("rst_out_addr",    out_addr,    0);
        check("rst_err_illegal", err_illegal, 0);
        check("rst_err_count",   err_count,   0);
        #1 rst_n = 1'b1;
        cmp_en = 1;

        // Pin the reference encoder with hand-computed words
        void'(model_enc(18, 1, 0, 0, 32'd5, pw));          check("pin_addi", pw, 32'h00500093);
        void'(model_enc(0, 2, 0, 0, 32'h12345000, pw));    check("pin_lui",  pw, 32'h12345137);
        void'(model_enc(28, 3, 1, 2, 32'd0, pw));          check("pin_sub",  pw, 32'h402081B3);
        void'(model_enc(4, 0, 1, 2, 32'd8, pw));           check("pin_beq",  pw, 32'h00208463);
        void'(model_enc(26, 5, 6, 0, 32'd3, pw));          check("pin_srai", pw, 32'h40335293);
        void'(model_enc(2, 1, 0, 0, 32'hFFFFFFFC, pw));    check("pin_jal",  pw, 32'hFFDFF0EF);
        check("pin_bad_addi", model_enc(18, 1, 0, 0, 32'd2048, pw), 0);
        check("pin_bad_beq",  model_enc(4, 0, 1, 2, 32'd3, pw), 0);

        // Basic encodes, one at a time, consumer always ready
        out_ready = 1'b1;
        send_expect("addi", 18, 1, 0, 0, 32'd5,         32'h00500093, 8'd0);
        send_expect("lui",   0, 2, 0, 0, 32'h12345000,  32'h12345137, 8'd1);
        send_expect("sub",  28, 3, 1, 2, 32'd0,         32'h402081B3, 8'd2);
        send_expect("beq",   4, 0, 1, 2, 32'd8,         32'h00208463, 8'd3);
        send_expect("srai", 26, 5, 6, 0, 32'd3,         32'h40335293, 8'd4);
        send_expect("jal",   2, 1, 0, 0, 32'hFFFFFFFC,  32'hFFDFF0EF, 8'd5);

        // Illegal requests
        send_bad("bad_addi", 18, 32'd2048);
        send_bad("bad_beq",   4, 32'd3);
        send_bad("bad_lui",   0, 32'h00001001);
        send_bad("bad_mnem", 40, 32'd0);
        check("err_count_4", err_count, 4);
        send_expect("xori", 21, 7, 8, 0, 32'hFFFFFFFF, 32'hFFF44393, 8'd6);

        // Backpressure: load address 0 in the same cycle the xori pops
        addr_load = 1'b1; addr_value = 8'd0;
        @(posedge clk); #1;
        addr_load = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        check("bp_empty", out_valid, 0);
        check("bp_addr0", out_addr, 0);
        void'(model_enc(27, 1, 2, 3, 32'd0, wa));
        void'(model_enc(36, 4, 5, 6, 32'd0, wb));
        void'(model_enc(35, 7, 8, 9, 32'd0, wc));
        drive_req(27, 1, 2, 3, 32'd0); wait_accept("bp_a");
        drive_req(36, 4, 5, 6, 32'd0); wait_accept("bp_b");
        check("bp_full_ready", in_ready, 0);
        check("bp_head_a", out_word, wa);
        drive_req(35, 7, 8, 9, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_hold_ready", in_ready, 0);
            check("bp_hold_word",  out_word, wa);
            check("bp_hold_addr",  out_addr, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_pop_b_word", out_word, wb);
        check("bp_pop_b_addr", out_addr, 1);
        check("bp_space",      in_ready, 1);
        wait_accept("bp_c");
        @(negedge clk);
        check("bp_c_word", out_word, wc);
        check("bp_c_addr", out_addr, 2);

        // Address load and wrap
        @(negedge clk);
        check("drain", out_valid, 0);
        addr_load = 1'b1; addr_value = 8'hFE;
        @(negedge clk);
        addr_load = 1'b0;
        check("load_fe", out_addr, 8'hFE);
        send_expect("wrap0", 18, 1, 1, 0, 32'd1, 32'h00108093, 8'hFE);
        send_expect("wrap1", 18, 1, 1, 0, 32'd2, 32'h00208093, 8'hFF);
        send_expect("wrap2", 18, 1, 1, 0, 32'd3, 32'h00308093, 8'h00);
        addr_load = 1'b1; addr_value = 8'h40;
        @(posedge clk); #1;
        addr_load = 1'b0;
        @(negedge clk);
        check("load_wins", out_addr, 8'h40);
        check("load_pop",  out_valid, 0);

        // Asynchronous reset with two words buffered
        out_ready = 1'b0;
        send_bad("bad_5", 50, 32'd0);
        drive_req(27, 1, 2, 3, 32'd0); wait_accept("rs_a");
        drive_req(36, 4, 5, 6, 32'd0); wait_accept("rs_b");
        @(negedge clk);
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_err",   err_count, 5);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_err_count", err_count, 0);
        check("arst_out_addr",  out_addr,  0);
        check("arst_in_ready",  in_ready,  0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            in_valid   = ($urandom_range(0, 9) < 7);
            out_ready  = ($urandom_range(0, 9) < 6);
            addr_load  = ($urandom_range(0, 99) < 3);
            addr_value = 8'($urandom);
            in_mnem    = 6'($urandom_range(0, 44));
            in_rd      = 5'($urandom);
            in_rs1     = 5'($urandom);
            in_rs2     = 5'($urandom);
            case ($urandom_range(0, 4))
                0:       in_imm = $urandom;
                1:       in_imm = 32'($urandom_range(0, 8191)) - 32'd4096;
                2:       in_imm = 32'($urandom_range(0, 2097151)) - 32'h00100000;
                3:       in_imm = BND[$urandom_range(0, 12)];
                default: in_imm = $urandom & 32'hFFFFF000;
            endcase
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
